word_split_64to32: RTL and testbench

Downstream width-conversion stage for the 64-bit `d` result bus. Accepts 64-bit words on a valid/ready handshake and emits them as two 32-bit halves on a second valid/ready handshake, tagging the second half with `out_last`. A single holding register sustains one output word per cycle under continuous traffic. A wrapping counter reports completed words to the register block.

---
 rtl/word_split_64to32.sv | 75 +++++++
 tb/tb_word_split_64to32.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/word_split_64to32.sv
// Width converter: buffers one IN_W-bit word and emits it as two OUT_W-bit halves,
// tagging the second half with out_last and counting every fully emitted word.
module word_split_64to32 #(
   parameter int IN_W      = 64,
   parameter int OUT_W     = 32,
   parameter int MSB_FIRST = 0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic [CNT_W-1:0] words_done
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [IN_W-1:0]  r_hold;
   logic             r_full;
   logic             r_half;
   logic [CNT_W-1:0] r_words_done;

   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_sel_hi;

   function automatic logic [OUT_W-1:0] pick_half(input logic [IN_W-1:0] word,
                                                  input logic            hi);
      return hi ? word[IN_W-1:OUT_W] : word[OUT_W-1:0];
   endfunction

   // A new word may only enter while the second half is leaving this very cycle,
   // so a single holding register still sustains one half per cycle.
   assign in_ready   = !rst && (!r_full || (r_half && out_ready));
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_full && out_ready;
   assign w_sel_hi   = r_half ^ (MSB_FIRST != 0);

   assign out_valid  = r_full;
   assign out_last   = r_full && r_half;
   assign out_data   = r_full ? pick_half(r_hold, w_sel_hi) : '0;
   assign words_done = r_words_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold       <= '0;
         r_full       <= 1'b0;
         r_half       <= 1'b0;
         r_words_done <= '0;
      end else begin
         if (w_in_fire) begin
            r_hold <= in_data;
            r_full <= 1'b1;
            r_half <= 1'b0;
         end else if (w_out_fire) begin
            if (!r_half) begin
               r_half <= 1'b1;
            end else begin
               r_full <= 1'b0;
               r_half <= 1'b0;
            end
         end
         // The count follows the second-half handshake even when a new word loads.
         if (w_out_fire && r_half) begin
            r_words_done <= r_words_done + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_word_split_64to32.sv
// Bench for word_split_64to32: two instances (LSB-first/16-bit count and
// MSB-first/4-bit count) share stimulus and are checked against a queue model.
module tb_word_split_64to32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [63:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic        in_ready0, out_valid0, out_last0;
   logic [31:0] out_data0;
   logic [15:0] words_done0;
   logic        in_ready1, out_valid1, out_last1;
   logic [31:0] out_data1;
   logic [3:0]  words_done1;

   int n_cmp = 0;
   int n_err = 0;

   // Model: halves still owed to downstream, in emission order.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          cnt0 = 0;
   int          cnt1 = 0;

   always #5 clk = ~clk;

   word_split_64to32 #(.IN_W(64), .OUT_W(32), .MSB_FIRST(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_last(out_last0), .words_done(words_done0));

   word_split_64to32 #(.IN_W(64), .OUT_W(32), .MSB_FIRST(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_last(out_last1), .words_done(words_done1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model update on each rising edge.
   initial begin
      forever begin
         bit ir;
         @(posedge clk);
         if (rst) begin
            q0.delete();
            q1.delete();
            cnt0 = 0;
            cnt1 = 0;
         end else begin
            ir = (q0.size() == 0) || (q0.size() == 1 && out_ready);
            if (q0.size() != 0 && out_ready) begin
               if (q0.size() == 1) begin
                  cnt0 = (cnt0 + 1) % 65536;
                  cnt1 = (cnt1 + 1) % 16;
               end
               void'(q0.pop_front());
               void'(q1.pop_front());
            end
            if (in_valid && ir) begin
               q0.push_back(in_data[31:0]);
               q0.push_back(in_data[63:32]);
               q1.push_back(in_data[63:32]);
               q1.push_back(in_data[31:0]);
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      chk("in_ready0", in_ready0, !rst && (q0.size() == 0 || (q0.size() == 1 && out_ready)));
      chk("in_ready1", in_ready1, !rst && (q1.size() == 0 || (q1.size() == 1 && out_ready)));
      if (!rst) begin
         chk("out_valid0", out_valid0, q0.size() != 0);
         chk("out_valid1", out_valid1, q1.size() != 0);
         chk("out_last0", out_last0, q0.size() == 1);
         chk("out_last1", out_last1, q1.size() == 1);
         chk("out_data0", out_data0, (q0.size() != 0) ? q0[0] : 32'h0);
         chk("out_data1", out_data1, (q1.size() != 0) ? q1[0] : 32'h0);
         chk("words_done0", words_done0, cnt0);
         chk("words_done1", words_done1, cnt1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) next_cycle();
      rst = 1'b0;
   endtask

   // One isolated word; first/second are the LSB-first halves.
   task automatic single_word(input logic [63:0] w, input logic [31:0] first,
                              input logic [31:0] second, input int wd_exp);
      in_valid = 1'b1;
      in_data = w;
      out_ready = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      chk("sw_first0", out_data0, first);
      chk("sw_first_last0", out_last0, 1'b0);
      chk("sw_first1", out_data1, second);
      next_cycle();
      @(negedge clk);
      chk("sw_second0", out_data0, second);
      chk("sw_second_last0", out_last0, 1'b1);
      chk("sw_second1", out_data1, first);
      next_cycle();
      @(negedge clk);
      chk("sw_idle0", out_valid0, 1'b0);
      chk("sw_words0", words_done0, wd_exp);
      next_cycle();
   endtask

   task automatic run_stream(input int n, input int pv, input int pr, input int budget,
                             output int vcycles);
      int sent = 0;
      int cyc = 0;
      bit fire;
      logic [63:0] w;
      vcycles = 0;
      w = {$urandom, $urandom};
      while ((sent < n || q0.size() != 0) && cyc < budget) begin
         in_valid = (sent < n) && ($urandom_range(99) < pv);
         in_data = w;
         out_ready = ($urandom_range(99) < pr);
         @(negedge clk);
         fire = in_valid && in_ready0;
         if (out_valid0) vcycles++;
         next_cycle();
         if (fire) begin
            sent++;
            w = {$urandom, $urandom};
         end
         cyc++;
      end
      in_valid = 1'b0;
      chk("stream_finished_in_budget", cyc < budget, 1'b1);
   endtask

   initial begin
      int vc;
      // Reset held for two cycles with in_valid high.
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 64'hFFFF_EEEE_DDDD_CCCC;
      out_ready = 1'b1;
      repeat (2) next_cycle();
      @(negedge clk);
      chk("rst_in_ready", in_ready0, 1'b0);
      chk("rst_out_valid", out_valid0, 1'b0);
      chk("rst_out_data", out_data0, 32'h0);
      chk("rst_words_done", words_done0, 16'h0);
      next_cycle();
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", in_ready0, 1'b1);
      next_cycle();

      single_word(64'h1122334455667788, 32'h55667788, 32'h11223344, 1);

      // Eight back-to-back words at full rate.
      run_stream(8, 100, 100, 100, vc);
      chk("stream_valid_cycles", vc, 16);
      @(negedge clk);
      chk("stream_words0", words_done0, 16'd9);
      next_cycle();

      // Backpressure for five cycles while the second half is pending.
      in_valid = 1'b1;
      in_data = 64'hA5A50F0F_FFFF1234;
      out_ready = 1'b1;
      next_cycle();
      in_data = 64'hDEADBEEF_01234567;
      next_cycle();
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_data", out_data0, 32'hA5A50F0F);
         chk("bp_last", out_last0, 1'b1);
         chk("bp_in_ready", in_ready0, 1'b0);
         next_cycle();
      end
      out_ready = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_word", out_data0, 32'h01234567);
      next_cycle();
      next_cycle();

      // Random valid/ready traffic.
      run_stream(60, 50, 50, 2000, vc);
      run_stream(40, 80, 30, 2000, vc);

      // Counter wrap on the 4-bit instance.
      do_reset();
      run_stream(17, 100, 100, 200, vc);
      @(negedge clk);
      chk("wrap_words0", words_done0, 16'd17);
      chk("wrap_words1", words_done1, 4'd1);
      next_cycle();

      // Reset after the first-half handshake.
      do_reset();
      in_valid = 1'b1;
      in_data = 64'h0BAD0BAD_600DF00D;
      out_ready = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      rst = 1'b1;
      out_ready = 1'b0;
      next_cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_valid0", out_valid0, 1'b0);
         chk("midrst_valid1", out_valid1, 1'b0);
         chk("midrst_words0", words_done0, 16'h0);
         next_cycle();
      end
      single_word(64'hCAFEF00D_13579BDF, 32'h13579BDF, 32'hCAFEF00D, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
